// File: rtl/mode_counter_fsm_if.sv
// Button, step and display-side signals of the mode counter, bundled so the
// board glue and the counter core share one connection point.
interface mode_counter_fsm_if #(
   parameter int COUNT_W = 16,
   parameter int STEP_W  = 4
);
   logic               in_btn_up_n;
   logic               in_btn_down_n;
   logic [STEP_W-1:0]  in_step;
   logic [1:0]         out_state;
   logic [COUNT_W-1:0] out_count;
   logic               out_tick;
   logic               out_limit;

   modport master (
      output in_btn_up_n, in_btn_down_n, in_step,
      input  out_state, out_count, out_tick, out_limit
   );

   modport slave (
      input  in_btn_up_n, in_btn_down_n, in_step,
      output out_state, out_count, out_tick, out_limit
   );
endinterface

// File: rtl/mode_counter_fsm.sv
// Mode counter: two debounced push buttons step a CLEAR/UP/DOWN/HOLD state
// machine; a free-running prescaler paces a wrap-or-saturate counter.
module mode_counter_fsm #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int COUNT_W         = 16,
   parameter int STEP_W          = 4,
   parameter bit WRAP            = 1'b1
) (
   input  logic              in_clk,
   input  logic              global_reset,
   mode_counter_fsm_if.slave bus
);

   localparam logic [1:0] ST_CLEAR = 2'b00;
   localparam logic [1:0] ST_UP    = 2'b01;
   localparam logic [1:0] ST_DOWN  = 2'b10;
   localparam logic [1:0] ST_HOLD  = 2'b11;

   localparam int              PS_W    = $clog2(TICK_DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
   localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   // bit 0 = up button, bit 1 = down button
   logic [1:0]         raw;
   logic [1:0]         sync_p0;
   logic [1:0]         sync_p1;
   logic               vld_p0;
   logic               vld_p1;
   logic [1:0]         deb;
   logic [DB_W-1:0]    db_cnt [2];
   logic [1:0]         prev;
   logic [1:0]         armed;
   logic [1:0]         press;

   logic [PS_W-1:0]    presc;
   logic               tick;

   logic [1:0]         state;
   logic [1:0]         state_next;

   logic [COUNT_W-1:0] count;
   logic               limit;
   logic [COUNT_W-1:0] step_ext;

   // Applies one step to the counter and reports whether the true result
   // left 0..2^COUNT_W-1; out-of-range results wrap or clamp per WRAP.
   function automatic logic [COUNT_W:0] apply_step(
      input logic [COUNT_W-1:0] cur,
      input logic [COUNT_W-1:0] step,
      input logic               down
   );
      logic signed [COUNT_W+1:0] full;
      logic                      over;
      logic                      under;
      logic [COUNT_W-1:0]        res;
      if (down)
         full = $signed({2'b00, cur}) - $signed({2'b00, step});
      else
         full = $signed({2'b00, cur}) + $signed({2'b00, step});
      under = full[COUNT_W+1];
      over  = ~full[COUNT_W+1] & full[COUNT_W];
      res   = full[COUNT_W-1:0];
      if (!WRAP && over)
         res = '1;
      if (!WRAP && under)
         res = '0;
      return {over | under, res};
   endfunction

   assign raw      = {bus.in_btn_down_n, bus.in_btn_up_n};
   assign step_ext = COUNT_W'(bus.in_step);

   // Two-flop synchronisers; vld_pN marks when sync_pN holds a real sample
   // rather than its reset value.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         sync_p0 <= '1;
         sync_p1 <= '1;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
      end
   end

   // Debouncers: accept a new level only after DEBOUNCE_CYCLES stable cycles.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         deb <= '1;
         for (int b = 0; b < 2; b++)
            db_cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (sync_p1[b] != deb[b]) begin
               if (db_cnt[b] == DB_LAST) begin
                  deb[b]    <= sync_p1[b];
                  db_cnt[b] <= '0;
               end else begin
                  db_cnt[b] <= db_cnt[b] + DB_W'(1);
               end
            end else begin
               db_cnt[b] <= '0;
            end
         end
      end
   end

   // Edge memory plus arming: a button only arms once it has been seen
   // released after reset, so a press held through reset never fires.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         prev  <= '1;
         armed <= '0;
      end else begin
         prev  <= deb;
         armed <= armed | ({2{vld_p1}} & sync_p1 & deb);
      end
   end

   assign press = armed & prev & ~deb;

   // Free-running prescaler; tick marks its last count.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset)
         presc <= '0;
      else if (tick)
         presc <= '0;
      else
         presc <= presc + PS_W'(1);
   end

   assign tick = (presc == PS_LAST);

   // Next mode from press events; simultaneous presses cancel out.
   always_comb begin
      state_next = state;
      if (press[0] != press[1]) begin
         case (state)
            ST_CLEAR: if (press[0]) state_next = ST_UP;
            ST_UP:    state_next = press[0] ? ST_DOWN : ST_CLEAR;
            ST_DOWN:  state_next = press[0] ? ST_HOLD : ST_UP;
            ST_HOLD:  if (press[1]) state_next = ST_DOWN;
            default:  state_next = ST_CLEAR;
         endcase
      end else if (state > ST_HOLD) begin
         state_next = ST_CLEAR;
      end
   end

   // Mode register.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset)
         state <= ST_CLEAR;
      else
         state <= state_next;
   end

   // Counter update using the mode held before this edge; limit is a
   // one-cycle flag registered with the update that wrapped or clamped.
   always_ff @(posedge in_clk or posedge global_reset) begin
      if (global_reset) begin
         count <= '0;
         limit <= 1'b0;
      end else begin
         limit <= 1'b0;
         case (state)
            ST_CLEAR: count <= '0;
            ST_UP:    if (tick) {limit, count} <= apply_step(count, step_ext, 1'b0);
            ST_DOWN:  if (tick) {limit, count} <= apply_step(count, step_ext, 1'b1);
            default:  count <= count;
         endcase
      end
   end

   assign bus.out_state = state;
   assign bus.out_count = count;
   assign bus.out_tick  = tick;
   assign bus.out_limit = limit;

endmodule
